// File: rtl/uart_bridge_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | uart_bridge_pkg : shared types and constants for the UART memory bridge    |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
package uart_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_MEM   = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  localparam logic [7:0] RESP_ACK     = 8'h4B;
  localparam logic [7:0] RESP_ERR     = 8'h45;
  localparam logic [7:0] OP_READ_DEF  = 8'h52;
  localparam logic [7:0] OP_WRITE_DEF = 8'h57;
  localparam int         TIMEOUT_DEF  = 1000000;

endpackage
`default_nettype wire

// File: rtl/uart_bridge_timeout.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | uart_bridge_timeout : inter-byte idle counter, pulses expire_o on the      |
// | TIMEOUT_CYCLES-th consecutive enabled cycle.  Revision: 1.0                |
// +---------------------------------------------------------------------------+
module uart_bridge_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int            CW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expire_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || expire_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_mem_bridge.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | uart_mem_bridge : decodes host read/write packets from the UART byte FIFO  |
// | into 32-bit memory requests and returns responses.  Revision: 1.0          |
// +---------------------------------------------------------------------------+
module uart_mem_bridge
  import uart_bridge_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter logic [7:0] OP_READ        = OP_READ_DEF,
  parameter logic [7:0] OP_WRITE       = OP_WRITE_DEF
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        receivable,
  input  logic [7:0]  recv_data,
  output logic        recv_flag,
  input  logic        sendable,
  output logic        send_flag,
  output logic [7:0]  send_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        pkt_err
);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  last_q, last_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] resp_q, resp_d;

  logic in_pkt;
  logic tmo_en;
  logic tmo_expire;

  // Gated by RST_N so the FIFO is never popped while reset is held.
  assign in_pkt    = (state_q == ST_ADDR) || (state_q == ST_WDATA);
  assign recv_flag = RST_N && receivable && (in_pkt || (state_q == ST_IDLE));
  assign tmo_en    = in_pkt && !receivable;

  uart_bridge_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .clr_i    (!tmo_en),
    .en_i     (tmo_en),
    .expire_o (tmo_expire)
  );

  assign mem_req   = (state_q == ST_MEM);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    resp_d    = resp_q;
    send_flag = 1'b0;
    send_data = 8'h00;
    pkt_err   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (recv_flag) begin
          cnt_d = 2'd0;
          if (recv_data == OP_READ) begin
            we_d    = 1'b0;
            state_d = ST_ADDR;
          end else if (recv_data == OP_WRITE) begin
            we_d    = 1'b1;
            state_d = ST_ADDR;
          end else begin
            resp_d  = {24'h0, RESP_ERR};
            last_d  = 2'd0;
            pkt_err = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_ADDR, ST_WDATA: begin
        if (tmo_expire) begin
          cnt_d   = 2'd0;
          pkt_err = 1'b1;
          state_d = ST_IDLE;
        end else if (recv_flag) begin
          if (state_q == ST_ADDR) begin
            addr_d[{cnt_q, 3'b000} +: 8] = recv_data;
          end else begin
            wdata_d[{cnt_q, 3'b000} +: 8] = recv_data;
          end
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = (state_q == ST_ADDR && we_q) ? ST_WDATA : ST_MEM;
          end
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          resp_d  = we_q ? {24'h0, RESP_ACK} : mem_rdata;
          last_d  = we_q ? 2'd0 : 2'd3;
          cnt_d   = 2'd0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (sendable) begin
          send_flag = 1'b1;
          send_data = resp_q[{cnt_q, 3'b000} +: 8];
          if (cnt_q == last_q) begin
            cnt_d   = 2'd0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      last_q  <= 2'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      resp_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_mem_bridge.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_uart_mem_bridge : directed self-checking bench for uart_mem_bridge      |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
module tb_uart_mem_bridge;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        receivable, sendable, mem_ack;
  logic [7:0]  recv_data;
  logic [31:0] mem_rdata;
  logic        recv_flag, send_flag, mem_req, mem_we, busy, pkt_err;
  logic [7:0]  send_data;
  logic [31:0] mem_addr, mem_wdata;

  uart_mem_bridge #(
    .TIMEOUT_CYCLES (16),
    .OP_READ        (8'h52),
    .OP_WRITE       (8'h57)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .receivable (receivable),
    .recv_data  (recv_data),
    .recv_flag  (recv_flag),
    .sendable   (sendable),
    .send_flag  (send_flag),
    .send_data  (send_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .busy       (busy),
    .pkt_err    (pkt_err)
  );

  always #5 CLK = ~CLK;

  logic [7:0]  rxq[$];
  logic [7:0]  sent[$];
  logic [3:0]  send_pat;
  logic [31:0] rd_val, cap_addr, cap_wdata, got;
  logic        cap_we, popped;
  int cyc, req_cycles, ack_delay, req_count, req_len, err_count, unstable;
  int err_cyc, ack_cyc, first_send_cyc, req_first_cyc, last_pop_cyc;
  int n_chk, n_pass;

  task automatic clear_stats();
    sent.delete();
    req_count = 0; req_len = 0; err_count = 0; unstable = 0; req_cycles = 0;
    err_cyc = -1; ack_cyc = -1; first_send_cyc = -1; req_first_cyc = -1; last_pop_cyc = -1;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) rxq.push_back(w[8*i +: 8]);
  endtask

  // One clock: drive FIFO / memory model, sample outputs, advance past the edge.
  task automatic cycle();
    receivable = (rxq.size() > 0);
    recv_data  = receivable ? rxq[0] : 8'h00;
    sendable   = send_pat[cyc % 4];
    #1;
    mem_ack   = mem_req && (req_cycles == ack_delay);
    mem_rdata = rd_val;
    #1;
    if (send_flag) begin
      sent.push_back(send_data);
      if (first_send_cyc < 0) first_send_cyc = cyc;
    end
    if (mem_req) begin
      if (req_cycles == 0) begin
        req_count++; req_first_cyc = cyc;
        cap_addr = mem_addr; cap_wdata = mem_wdata; cap_we = mem_we;
      end else if (mem_addr !== cap_addr || mem_wdata !== cap_wdata || mem_we !== cap_we) begin
        unstable++;
      end
      req_len++;
      if (mem_ack) ack_cyc = cyc;
      req_cycles++;
    end else begin
      req_cycles = 0;
    end
    if (pkt_err) begin err_count++; err_cyc = cyc; end
    popped = recv_flag;
    if (recv_flag) last_pop_cyc = cyc;
    @(posedge CLK);
    if (popped) rxq.delete(0);
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic test_reset();
    n_chk++; if (recv_flag !== 1'b0) $display("FAIL rst_recv_flag got %0b exp 0", recv_flag); else n_pass++;
    n_chk++; if (send_flag !== 1'b0) $display("FAIL rst_send_flag got %0b exp 0", send_flag); else n_pass++;
    n_chk++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req got %0b exp 0", mem_req); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy got %0b exp 0", busy); else n_pass++;
    n_chk++; if (pkt_err !== 1'b0) $display("FAIL rst_pkt_err got %0b exp 0", pkt_err); else n_pass++;
    n_chk++; if ({mem_addr, mem_wdata, send_data, mem_we} !== 73'h0)
      $display("FAIL rst_data got addr=%h wdata=%h sd=%h we=%b exp 0", mem_addr, mem_wdata, send_data, mem_we);
    else n_pass++;
    @(posedge CLK); #1;
    RST_N = 1'b1; receivable = 1'b0;
    #1;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_release_busy got %0b exp 0", busy); else n_pass++;
  endtask

  task automatic test_write();
    clear_stats(); ack_delay = 3;
    rxq.push_back(8'h57); push_word(32'h0000_0010); push_word(32'hDEAD_BEEF);
    run(40);
    n_chk++; if (req_count !== 1) $display("FAIL wr_req_count got %0d exp 1", req_count); else n_pass++;
    n_chk++; if (cap_we !== 1'b1) $display("FAIL wr_we got %0b exp 1", cap_we); else n_pass++;
    n_chk++; if (cap_addr !== 32'h10) $display("FAIL wr_addr got %h exp 00000010", cap_addr); else n_pass++;
    n_chk++; if (cap_wdata !== 32'hDEADBEEF) $display("FAIL wr_wdata got %h exp deadbeef", cap_wdata); else n_pass++;
    n_chk++; if (req_len !== 4) $display("FAIL wr_req_len got %0d exp 4", req_len); else n_pass++;
    n_chk++; if (unstable !== 0) $display("FAIL wr_req_stable got %0d changes exp 0", unstable); else n_pass++;
    n_chk++; if (sent.size() !== 1 || sent[0] !== 8'h4B)
      $display("FAIL wr_resp got %0d bytes first=%h exp 1 byte 4b", sent.size(), (sent.size() > 0) ? sent[0] : 8'hxx);
    else n_pass++;
    n_chk++; if (busy !== 1'b0 || err_count !== 0) $display("FAIL wr_idle got busy=%b errs=%0d exp 0/0", busy, err_count); else n_pass++;
  endtask

  task automatic test_read();
    clear_stats(); ack_delay = 0; rd_val = 32'h1234_5678;
    rxq.push_back(8'h52); push_word(32'h0000_0010);
    run(30);
    got = 32'hxxxx_xxxx;
    if (sent.size() == 4) got = {sent[3], sent[2], sent[1], sent[0]};
    n_chk++; if (got !== 32'h12345678) $display("FAIL rd_bytes got %0d bytes %h exp 4 bytes 12345678", sent.size(), got); else n_pass++;
    n_chk++; if (req_len !== 1 || req_count !== 1) $display("FAIL rd_req_len got %0d/%0d exp 1/1", req_len, req_count); else n_pass++;
    n_chk++; if (cap_we !== 1'b0 || cap_addr !== 32'h10) $display("FAIL rd_req got we=%b addr=%h exp 0/00000010", cap_we, cap_addr); else n_pass++;
    n_chk++; if (req_first_cyc !== last_pop_cyc + 1) $display("FAIL rd_req_rise got cyc %0d exp %0d", req_first_cyc, last_pop_cyc + 1); else n_pass++;
    n_chk++; if (first_send_cyc !== ack_cyc + 1) $display("FAIL rd_first_send got cyc %0d exp %0d", first_send_cyc, ack_cyc + 1); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rd_busy got %0b exp 0", busy); else n_pass++;
  endtask

  task automatic test_send_stall();
    clear_stats(); ack_delay = 1; rd_val = 32'hA1B2_C3D4; send_pat = 4'b1001;
    rxq.push_back(8'h52); push_word(32'h0000_0100);
    run(40);
    send_pat = 4'b1111;
    got = 32'hxxxx_xxxx;
    if (sent.size() == 4) got = {sent[3], sent[2], sent[1], sent[0]};
    n_chk++; if (sent.size() !== 4) $display("FAIL stall_count got %0d exp 4", sent.size()); else n_pass++;
    n_chk++; if (got !== 32'hA1B2C3D4) $display("FAIL stall_bytes got %h exp a1b2c3d4", got); else n_pass++;
    n_chk++; if (cap_addr !== 32'h100) $display("FAIL stall_addr got %h exp 00000100", cap_addr); else n_pass++;
  endtask

  task automatic test_bad_opcode();
    clear_stats(); ack_delay = 0;
    rxq.push_back(8'h33);
    run(10);
    n_chk++; if (err_count !== 1) $display("FAIL bad_err got %0d exp 1", err_count); else n_pass++;
    n_chk++; if (sent.size() !== 1 || sent[0] !== 8'h45)
      $display("FAIL bad_resp got %0d bytes first=%h exp 1 byte 45", sent.size(), (sent.size() > 0) ? sent[0] : 8'hxx);
    else n_pass++;
    n_chk++; if (req_count !== 0) $display("FAIL bad_req got %0d exp 0", req_count); else n_pass++;
    clear_stats(); rd_val = 32'hCAFE_F00D;
    rxq.push_back(8'h52); push_word(32'h0000_0020);
    run(30);
    got = 32'hxxxx_xxxx;
    if (sent.size() == 4) got = {sent[3], sent[2], sent[1], sent[0]};
    n_chk++; if (got !== 32'hCAFEF00D || cap_addr !== 32'h20)
      $display("FAIL bad_next_read got data=%h addr=%h exp cafef00d/00000020", got, cap_addr);
    else n_pass++;
  endtask

  task automatic test_timeout();
    clear_stats(); ack_delay = 0;
    rxq.push_back(8'h52); rxq.push_back(8'h10);
    run(22);
    n_chk++; if (err_count !== 1) $display("FAIL tmo_err got %0d exp 1", err_count); else n_pass++;
    n_chk++; if (err_cyc !== last_pop_cyc + 16) $display("FAIL tmo_cycle got %0d exp %0d", err_cyc, last_pop_cyc + 16); else n_pass++;
    n_chk++; if (req_count !== 0 || sent.size() !== 0) $display("FAIL tmo_side got req=%0d sent=%0d exp 0/0", req_count, sent.size()); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL tmo_busy got %0b exp 0", busy); else n_pass++;
    clear_stats(); ack_delay = 2; rd_val = 32'h0BAD_F00D;
    rxq.push_back(8'h52); push_word(32'h1122_3344);
    run(30);
    got = 32'hxxxx_xxxx;
    if (sent.size() == 4) got = {sent[3], sent[2], sent[1], sent[0]};
    n_chk++; if (got !== 32'h0BADF00D || cap_addr !== 32'h11223344)
      $display("FAIL tmo_next_read got data=%h addr=%h exp 0badf00d/11223344", got, cap_addr);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    clear_stats(); ack_delay = 1000;
    rxq.push_back(8'h57); push_word(32'h0000_0008); push_word(32'h5555_AAAA);
    for (int i = 0; i < 30 && req_count == 0; i++) cycle();
    n_chk++; if (mem_req !== 1'b1) $display("FAIL rmid_pre_req got %0b exp 1", mem_req); else n_pass++;
    receivable = 1'b1; recv_data = 8'h52;
    RST_N = 1'b0; mem_ack = 1'b0;
    #1;
    n_chk++; if (mem_req !== 1'b0 || busy !== 1'b0) $display("FAIL rmid_req got req=%b busy=%b exp 0/0", mem_req, busy); else n_pass++;
    n_chk++; if ({mem_addr, mem_wdata, mem_we, recv_flag, send_flag, pkt_err} !== 68'h0)
      $display("FAIL rmid_outs got addr=%h wdata=%h we=%b rf=%b sf=%b err=%b exp 0",
               mem_addr, mem_wdata, mem_we, recv_flag, send_flag, pkt_err);
    else n_pass++;
    rxq.delete();
    @(posedge CLK); @(posedge CLK); #1;
    RST_N = 1'b1;
    clear_stats(); ack_delay = 1;
    rxq.push_back(8'h57); push_word(32'h0000_0004); push_word(32'h4433_2211);
    run(30);
    n_chk++; if (req_count !== 1 || cap_addr !== 32'h4 || cap_wdata !== 32'h44332211 || cap_we !== 1'b1)
      $display("FAIL rmid_write got n=%0d addr=%h wdata=%h we=%b exp 1/00000004/44332211/1", req_count, cap_addr, cap_wdata, cap_we);
    else n_pass++;
    n_chk++; if (sent.size() !== 1 || sent[0] !== 8'h4B)
      $display("FAIL rmid_resp got %0d bytes first=%h exp 1 byte 4b", sent.size(), (sent.size() > 0) ? sent[0] : 8'hxx);
    else n_pass++;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0;
    RST_N = 1'b0; receivable = 1'b1; recv_data = 8'h52; sendable = 1'b1;
    mem_ack = 1'b0; mem_rdata = 32'h0; rd_val = 32'h0; send_pat = 4'b1111; ack_delay = 0;
    clear_stats();
    #2;
    test_reset();
    test_write();
    test_read();
    test_send_stall();
    test_bad_opcode();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_mem_bridge.md
Name: uart_mem_bridge

Overview:
- Byte-level packet engine that sits on the CPU side of the UART byte-FIFO block.
- Consumes received bytes through that block's receivable/recv_flag/recv_data interface and decodes host read/write packets.
- Issues 32-bit memory requests with a req/ack handshake.
- Returns responses through the sendable/send_flag/send_data interface. This is the host debug/program-load path into CPU memory.

Parameters:
- TIMEOUT_CYCLES, 1000000, max idle cycles between bytes inside one packet before the packet is discarded.
- OP_READ, 8'h52, opcode byte for a read.
- OP_WRITE, 8'h57, opcode byte for a write.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  reset, asynchronous, active-low.
- receivable  in  1  UART receive FIFO non-empty.
- recv_data  in  8  UART receive FIFO head byte; first-word-fall-through, valid while receivable=1.
- recv_flag  out  1  one-cycle pop of receive FIFO.
- sendable  in  1  UART send FIFO not full.
- send_flag  out  1  one-cycle push to send FIFO.
- send_data  out  8  byte pushed; valid when send_flag=1.
- mem_req  out  1  memory request, held until acked.
- mem_we  out  1  1=write, 0=read; stable while mem_req=1.
- mem_addr  out  32  byte address; stable while mem_req=1.
- mem_wdata  out  32  write data; stable while mem_req=1.
- mem_rdata  in  32  read data, sampled on the mem_ack cycle.
- mem_ack  in  1  request completion; ignored while mem_req=0.
- busy  out  1  1 in any state except IDLE.
- pkt_err  out  1  one-cycle pulse on bad opcode or timeout.

Behaviour:
- Reset values (async, RST_N=0): all outputs 0, state IDLE, byte counter 0, timeout counter 0, address/data registers 0.
- Packet format:
  - Opcode byte, then 4 address bytes little-endian.
  - Write packets follow with 4 data bytes little-endian.
  - Response to a read: 4 rdata bytes LE.
  - Response to a write: one byte 8'h4B.
  - Response to a bad opcode: one byte 8'h45.
- Receive rule: recv_flag=1 only when receivable=1 and state is IDLE/ADDR/WDATA. The byte on recv_data is captured in that same cycle. At most one byte is consumed per cycle.
- Send rule: send_flag=1 only when sendable=1 and state is RESP. At most one byte is sent per cycle.
- States and transitions:
  - IDLE: on a consumed byte:
    - OP_READ -> ADDR with we=0.
    - OP_WRITE -> ADDR with we=1.
    - Any other byte -> RESP with the error byte queued and pkt_err pulsed.
  - ADDR: consumed byte k (0..3) goes to mem_addr[8k+7:8k]. After k=3: -> WDATA if we=1, else -> MEM.
  - WDATA: consumed byte k goes to mem_wdata[8k+7:8k]. After k=3 -> MEM.
  - MEM:
    - mem_req rises on the first cycle in MEM, i.e. the cycle after the last packet byte is consumed.
    - On mem_ack=1: latch mem_rdata (read only), drop mem_req the next cycle, -> RESP.
    - Zero-wait ack (ack in the first req cycle) is legal.
  - RESP:
    - Emit response bytes; rdata is sent byte 0 first.
    - The first send_flag is no earlier than the cycle after ack.
    - If sendable=0, stall with no byte lost or duplicated.
    - After the last byte -> IDLE.
- Byte counter is 2 bits, wraps 3->0 on each phase change.
- Timeout:
  - In ADDR/WDATA the counter increments each cycle without a consumed byte and clears on each consumed byte.
  - When it reaches TIMEOUT_CYCLES-1: -> IDLE, pkt_err pulse, no response, no memory access.
  - No timeout in MEM or RESP.
- Simultaneous events:
  - In the cycle RESP completes, no receive byte is consumed; the next packet starts the following cycle.
  - The timeout expiry cycle does not consume a byte.
- Reset mid-operation: immediate return to IDLE with all outputs 0, even while mem_req=1. The memory side must tolerate an abandoned request.

Decomposition:
- Shared package uart_bridge_pkg holds:
  - state encoding localparams (IDLE, ADDR, WDATA, MEM, RESP);
  - response byte constants RESP_ACK=8'h4B and RESP_ERR=8'h45;
  - opcode defaults.
- One sub-module is natural: uart_bridge_timeout, the inter-byte timeout counter with clear/enable inputs and an expire pulse output.
- Everything else is a single FSM.

Test Plan:
- Write with receivable always 1: 57 10 00 00 00 EF BE AD DE -> one mem_req with we=1, addr=0x00000010, wdata=0xDEADBEEF. Ack after 3 cycles -> single send_data=0x4B, busy low afterwards.
- Read: 52 10 00 00 00, mem_rdata=0x12345678 with zero-wait ack -> send bytes 78,56,34,12 in order; mem_req high exactly 1 cycle.
- Read response with sendable toggling 1,0,0,1,... -> exactly 4 send_flag pulses with the correct bytes, no duplicates.
- Bad opcode 0x33 -> pkt_err pulse, send 0x45, no mem_req. A following valid read still works.
- TIMEOUT_CYCLES=16: send 52 10 then stall 20 cycles -> pkt_err at the 16th idle cycle, no mem_req, no send. Next packet decodes correctly.
- Reset mid-packet: assert RST_N=0 during MEM with mem_req=1 -> all outputs 0 immediately. After release, IDLE and a fresh write completes.
